// File: rtl/irq_ctx_sequencer.sv
// ---------------------------------------------------------------------------
// irq_ctx_sequencer
//
// Interrupt entry / return sequencer. Detects rising edges on N_IRQ request
// lines, picks the lowest-index unmasked pending channel, flushes and stalls
// the pipeline, pushes the {flags, PC} context to the stack one DATA_W word
// at a time (least-significant word first), then loads the channel vector.
// On rti the context is popped back (most-significant word first) and the
// PC and flags are restored with a single ret_load strobe.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   irq, irq_mask     request lines (rising edge = request), 1 = masked
//   rti               return-from-interrupt pulse
//   pc_in, flags_in   context to save on entry
//   push_ready        stack accepts push_data this cycle
//   pop_valid/data    popped stack word
//   flush, stall      pipeline control
//   push_valid/data   context word push
//   pop_req           context pop request
//   vec_load, vec_pc  vector PC load strobe and address
//   ret_load, ret_pc, ret_flags  context restore strobe and values
//   busy              high whenever not IDLE
//   active_id         channel currently (or last) in service
// ---------------------------------------------------------------------------
module irq_ctx_sequencer #(
    parameter int N_IRQ      = 4,
    parameter int DATA_W     = 16,
    parameter int PC_W       = 32,
    parameter int FLAG_W     = 3,
    parameter int VEC_BASE   = 0,
    parameter int VEC_STRIDE = 2,
    localparam int ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
    localparam int CTX_WORDS = (PC_W + FLAG_W + DATA_W - 1) / DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_IRQ-1:0]     irq,
    input  logic [N_IRQ-1:0]     irq_mask,
    input  logic                 rti,
    input  logic [PC_W-1:0]      pc_in,
    input  logic [FLAG_W-1:0]    flags_in,
    input  logic                 push_ready,
    input  logic                 pop_valid,
    input  logic [DATA_W-1:0]    pop_data,
    output logic                 flush,
    output logic                 stall,
    output logic                 push_valid,
    output logic [DATA_W-1:0]    push_data,
    output logic                 pop_req,
    output logic                 vec_load,
    output logic [PC_W-1:0]      vec_pc,
    output logic                 ret_load,
    output logic [PC_W-1:0]      ret_pc,
    output logic [FLAG_W-1:0]    ret_flags,
    output logic                 busy,
    output logic [ID_W-1:0]      active_id
);

    localparam int CNT_W = (CTX_WORDS > 1) ? $clog2(CTX_WORDS) : 1;
    localparam int CTX_W = CTX_WORDS * DATA_W;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(CTX_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_PUSH, S_VECTOR, S_SERVICE, S_POP, S_RESUME
    } state_t;

    state_t              state_q, state_d;
    logic [N_IRQ-1:0]    irq_hist_q, pending_q, pending_d, rise, clr, req;
    logic [CTX_W-1:0]    ctx_q, ctx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     active_id_q, active_id_d, win_id;
    logic [PC_W-1:0]     vec_addr;

    logic                flush_q, flush_d, stall_q, stall_d;
    logic                push_valid_q, push_valid_d, pop_req_q, pop_req_d;
    logic                vec_load_q, vec_load_d, ret_load_q, ret_load_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   push_data_q, push_data_d;
    logic [PC_W-1:0]     vec_pc_q, vec_pc_d, ret_pc_q, ret_pc_d;
    logic [FLAG_W-1:0]   ret_flags_q, ret_flags_d;

    // Per-channel edge capture; a new edge beats an acceptance clear so an
    // edge arriving in the accept cycle is not lost.
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pend
        assign rise[gi]      = irq[gi] & ~irq_hist_q[gi];
        assign pending_d[gi] = rise[gi] | (pending_q[gi] & ~clr[gi]);
    end

    assign req = pending_q & ~irq_mask;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        win_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (req[i]) win_id = ID_W'(i);
        end
    end

    assign vec_addr = PC_W'(VEC_BASE) + PC_W'(active_id_q) * PC_W'(VEC_STRIDE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctx_d       = ctx_q;
        active_id_d = active_id_q;
        clr         = '0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    active_id_d  = win_id;
                    clr[win_id]  = 1'b1;
                    state_d      = S_FLUSH;
                end
            end
            S_FLUSH: begin
                ctx_d   = CTX_W'({flags_in, pc_in});
                cnt_d   = '0;
                state_d = S_PUSH;
            end
            S_PUSH: begin
                if (push_ready) begin
                    if (cnt_q == LAST_WORD) state_d = S_VECTOR;
                    else                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_VECTOR:  state_d = S_SERVICE;
            S_SERVICE: begin
                if (rti) begin
                    cnt_d   = LAST_WORD;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                if (pop_valid) begin
                    ctx_d[int'(cnt_q)*DATA_W +: DATA_W] = pop_data;
                    if (cnt_q == '0) state_d = S_RESUME;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            S_RESUME:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered
        // for exactly the cycles the FSM spends in each state.
        flush_d      = (state_d == S_FLUSH) || (state_d == S_RESUME);
        stall_d      = state_d inside {S_FLUSH, S_PUSH, S_VECTOR, S_POP, S_RESUME};
        push_valid_d = (state_d == S_PUSH);
        push_data_d  = push_valid_d ? ctx_d[int'(cnt_d)*DATA_W +: DATA_W] : '0;
        pop_req_d    = (state_d == S_POP);
        vec_load_d   = (state_d == S_VECTOR);
        vec_pc_d     = vec_load_d ? vec_addr : '0;
        ret_load_d   = (state_d == S_RESUME);
        ret_pc_d     = ret_load_d ? ctx_d[PC_W-1:0] : '0;
        ret_flags_d  = ret_load_d ? ctx_d[PC_W+FLAG_W-1:PC_W] : '0;
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            irq_hist_q   <= '0;
            pending_q    <= '0;
            ctx_q        <= '0;
            cnt_q        <= '0;
            active_id_q  <= '0;
            flush_q      <= 1'b0;
            stall_q      <= 1'b0;
            push_valid_q <= 1'b0;
            push_data_q  <= '0;
            pop_req_q    <= 1'b0;
            vec_load_q   <= 1'b0;
            vec_pc_q     <= '0;
            ret_load_q   <= 1'b0;
            ret_pc_q     <= '0;
            ret_flags_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_hist_q   <= irq;
            pending_q    <= pending_d;
            ctx_q        <= ctx_d;
            cnt_q        <= cnt_d;
            active_id_q  <= active_id_d;
            flush_q      <= flush_d;
            stall_q      <= stall_d;
            push_valid_q <= push_valid_d;
            push_data_q  <= push_data_d;
            pop_req_q    <= pop_req_d;
            vec_load_q   <= vec_load_d;
            vec_pc_q     <= vec_pc_d;
            ret_load_q   <= ret_load_d;
            ret_pc_q     <= ret_pc_d;
            ret_flags_q  <= ret_flags_d;
            busy_q       <= busy_d;
        end
    end

    assign flush      = flush_q;
    assign stall      = stall_q;
    assign push_valid = push_valid_q;
    assign push_data  = push_data_q;
    assign pop_req    = pop_req_q;
    assign vec_load   = vec_load_q;
    assign vec_pc     = vec_pc_q;
    assign ret_load   = ret_load_q;
    assign ret_pc     = ret_pc_q;
    assign ret_flags  = ret_flags_q;
    assign busy       = busy_q;
    assign active_id  = active_id_q;

endmodule

// File: tb/tb_irq_ctx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_irq_ctx_sequencer
//
// Directed bench for irq_ctx_sequencer with default parameters
// (CTX_WORDS = 3). Inputs are driven 1 ns after the rising edge and outputs
// are observed at the same point, i.e. the values held for the coming cycle.
// ---------------------------------------------------------------------------
module tb_irq_ctx_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq = '0, irq_mask = '0;
    logic        rti = 1'b0;
    logic [31:0] pc_in = '0;
    logic [2:0]  flags_in = '0;
    logic        push_ready = 1'b0, pop_valid = 1'b0;
    logic [15:0] pop_data = '0;

    logic        flush, stall, push_valid, pop_req, vec_load, ret_load, busy;
    logic [15:0] push_data;
    logic [31:0] vec_pc, ret_pc;
    logic [2:0]  ret_flags;
    logic [1:0]  active_id;
    logic [91:0] all_out;

    int n_tests = 0;
    int n_fail  = 0;

    irq_ctx_sequencer dut (
        .clk(clk), .reset(reset), .irq(irq), .irq_mask(irq_mask), .rti(rti),
        .pc_in(pc_in), .flags_in(flags_in), .push_ready(push_ready),
        .pop_valid(pop_valid), .pop_data(pop_data), .flush(flush), .stall(stall),
        .push_valid(push_valid), .push_data(push_data), .pop_req(pop_req),
        .vec_load(vec_load), .vec_pc(vec_pc), .ret_load(ret_load),
        .ret_pc(ret_pc), .ret_flags(ret_flags), .busy(busy), .active_id(active_id)
    );

    assign all_out = {flush, stall, push_valid, push_data, pop_req, vec_load,
                      vec_pc, ret_load, ret_pc, ret_flags, busy, active_id};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raise irq_v, then follow the entry sequence until SERVICE is reached.
    task automatic drive_entry(input logic [3:0] irq_v, output int first_flush,
                               output int n_flush, output int n_push,
                               output logic [47:0] words, output int n_vec,
                               output int vec_k, output logic [31:0] vpc,
                               output logic [1:0] aid, output bit done);
        first_flush = -1; n_flush = 0; n_push = 0; words = '0;
        n_vec = 0; vec_k = -1; vpc = '0; aid = '0; done = 1'b0;
        irq = irq_v;
        for (int k = 1; k <= 40; k++) begin
            tick;
            irq = 4'b0000;
            if (flush) begin
                n_flush++;
                if (first_flush < 0) first_flush = k;
            end
            if (push_valid && push_ready && n_push < 3) begin
                words[n_push*16 +: 16] = push_data;
                n_push++;
            end
            if (vec_load) begin
                n_vec++; vec_k = k; vpc = vec_pc; aid = active_id;
            end
            if (busy && !stall && n_vec > 0) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    // From SERVICE: pulse rti and feed the words back MSW first, with a gap
    // cycle before each pop. Stops at the RESUME cycle.
    task automatic drive_return(input logic [47:0] w, output logic [31:0] rpc,
                                output logic [2:0] rfl, output logic rflush,
                                output bit done);
        int n;
        n = 0; rpc = '0; rfl = '0; rflush = 1'b0; done = 1'b0;
        rti = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick;
            rti = 1'b0;
            pop_valid = 1'b0;
            if (ret_load) begin
                rpc = ret_pc; rfl = ret_flags; rflush = flush; done = 1'b1;
                break;
            end
            if (pop_req && (k % 2 == 0) && n < 3) begin
                pop_valid = 1'b1;
                pop_data  = w[(2-n)*16 +: 16];
                n++;
            end
        end
    endtask

    int          ff, nf, np, nv, vk;
    logic [47:0] ws;
    logic [31:0] vp, rp;
    logic [1:0]  ai;
    logic [2:0]  rf;
    logic        rfl_flush;
    bit          ok;

    task automatic test_reset;
        reset = 1'b0;
        #12;
        n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        @(negedge clk);
        reset = 1'b1;
        tick;
        n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL reset_release_idle: got %h want 0", all_out); end
    endtask

    task automatic test_basic_entry;
        pc_in = 32'h0001_2345; flags_in = 3'b101; push_ready = 1'b1; irq_mask = 4'b0000;
        drive_entry(4'b0100, ff, nf, np, ws, nv, vk, vp, ai, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL entry_done: got %0d want 1", ok); end
        n_tests++; if (ff !== 2) begin n_fail++; $display("FAIL entry_flush_cycle: got %0d want 2", ff); end
        n_tests++; if (nf !== 1) begin n_fail++; $display("FAIL entry_flush_count: got %0d want 1", nf); end
        n_tests++; if (np !== 3) begin n_fail++; $display("FAIL entry_push_count: got %0d want 3", np); end
        n_tests++; if (ws !== 48'h0005_0001_2345) begin n_fail++; $display("FAIL entry_push_words: got %h want 000500012345", ws); end
        n_tests++; if (nv !== 1) begin n_fail++; $display("FAIL entry_vec_count: got %0d want 1", nv); end
        n_tests++; if (vk !== 6) begin n_fail++; $display("FAIL entry_vec_cycle: got %0d want 6", vk); end
        n_tests++; if (vp !== 32'h0000_0004) begin n_fail++; $display("FAIL entry_vec_pc: got %h want 00000004", vp); end
        n_tests++; if (ai !== 2'd2) begin n_fail++; $display("FAIL entry_active_id: got %0d want 2", ai); end
        n_tests++; if (all_out !== {89'd0, 1'b1, 2'd2}) begin n_fail++; $display("FAIL service_outputs: got %h want only busy and id 2", all_out); end
    endtask

    task automatic test_return;
        drive_return(48'h0005_0001_2345, rp, rf, rfl_flush, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL return_done: got %0d want 1", ok); end
        n_tests++; if (rp !== 32'h0001_2345) begin n_fail++; $display("FAIL return_pc: got %h want 00012345", rp); end
        n_tests++; if (rf !== 3'b101) begin n_fail++; $display("FAIL return_flags: got %b want 101", rf); end
        n_tests++; if (rfl_flush !== 1'b1) begin n_fail++; $display("FAIL return_flush: got %b want 1", rfl_flush); end
        tick;
        n_tests++; if ({ret_load, busy} !== 2'b00) begin n_fail++; $display("FAIL return_busy_fall: got %b want 00", {ret_load, busy}); end
        n_tests++; if (ret_pc !== 32'h0) begin n_fail++; $display("FAIL return_pc_cleared: got %h want 0", ret_pc); end
    endtask

    task automatic test_priority_mask;
        int n_busy;
        pc_in = 32'h0000_0100; flags_in = 3'b010; irq_mask = 4'b0010;
        drive_entry(4'b1010, ff, nf, np, ws, nv, vk, vp, ai, ok);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL prio_done: got %0d want 1", ok); end
        n_tests++; if (ai !== 2'd3) begin n_fail++; $display("FAIL prio_active_id: got %0d want 3", ai); end
        n_tests++; if (vp !== 32'd6) begin n_fail++; $display("FAIL prio_vec_pc: got %h want 6", vp); end
        n_tests++; if (ws !== 48'h0002_0000_0100) begin n_fail++; $display("FAIL prio_push_words: got %h want 000200000100", ws); end
        drive_return(ws, rp, rf, rfl_flush, ok);
        n_tests++; if (rp !== 32'h0000_0100 || rf !== 3'b010) begin n_fail++; $display("FAIL prio_return: got %h/%b want 00000100/010", rp, rf); end
        n_busy = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (busy) n_busy++;
        end
        n_tests++; if (n_busy !== 0) begin n_fail++; $display("FAIL prio_masked_hold: got %0d busy cycles want 0", n_busy); end
        irq_mask = 4'b0000;
        drive_entry(4'b0000, ff, nf, np, ws, nv, vk, vp, ai, ok);
        n_tests++; if (ok !== 1'b1 || ai !== 2'd1) begin n_fail++; $display("FAIL unmask_active_id: got %0d (done %0d) want 1", ai, ok); end
        n_tests++; if (vp !== 32'd2) begin n_fail++; $display("FAIL unmask_vec_pc: got %h want 2", vp); end
        drive_return(ws, rp, rf, rfl_flush, ok);
        tick;
    endtask

    task automatic test_backpressure;
        int          j, n_acc, acc_k, v_k;
        logic [5:0]  pat;
        logic [47:0] exp_w;
        logic [31:0] vpc_seen;
        j = 0; n_acc = 0; acc_k = -1; v_k = -1; vpc_seen = '0;
        pat   = 6'b110100;
        exp_w = 48'h0003_ABCD_1234;
        pc_in = 32'hABCD_1234; flags_in = 3'b011; push_ready = 1'b0;
        irq = 4'b0010;
        for (int k = 1; k <= 40; k++) begin
            tick;
            irq = 4'b0000;
            push_ready = 1'b0;
            if (vec_load) begin
                v_k = k; vpc_seen = vec_pc;
                break;
            end
            if (push_valid) begin
                n_tests++;
                if (push_data !== exp_w[(n_acc % 3)*16 +: 16]) begin
                    n_fail++; $display("FAIL bp_push_data: got %h want %h (word %0d)", push_data, exp_w[(n_acc % 3)*16 +: 16], n_acc);
                end
                push_ready = (j < 6) ? pat[j] : 1'b1;
                j++;
                if (push_ready) begin n_acc++; acc_k = k; end
            end
        end
        n_tests++; if (n_acc !== 3) begin n_fail++; $display("FAIL bp_accept_count: got %0d want 3", n_acc); end
        n_tests++; if (j !== 6) begin n_fail++; $display("FAIL bp_push_cycles: got %0d want 6", j); end
        n_tests++; if (v_k !== acc_k + 1) begin n_fail++; $display("FAIL bp_vec_timing: got %0d want %0d", v_k, acc_k + 1); end
        n_tests++; if (vpc_seen !== 32'd2) begin n_fail++; $display("FAIL bp_vec_pc: got %h want 2", vpc_seen); end
        push_ready = 1'b1;
        tick;
        drive_return(exp_w, rp, rf, rfl_flush, ok);
        n_tests++; if (rp !== 32'hABCD_1234 || rf !== 3'b011) begin n_fail++; $display("FAIL bp_return: got %h/%b want abcd1234/011", rp, rf); end
        tick;
    endtask

    task automatic test_back_to_back;
        int bad;
        bad = 0;
        rti = 1'b1;
        tick;
        rti = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (busy || pop_req || ret_load || stall) bad++;
            tick;
        end
        n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL stray_rti: got %0d active cycles want 0", bad); end
        pc_in = 32'h0001_2345; flags_in = 3'b101;
        drive_entry(4'b0100, ff, nf, np, ws, nv, vk, vp, ai, ok);
        n_tests++; if (ok !== 1'b1 || vp !== 32'd4) begin n_fail++; $display("FAIL b2b_first_vec: got %h (done %0d) want 4", vp, ok); end
        irq = 4'b0001;
        tick;
        irq = 4'b0000;
        tick;
        n_tests++; if ({busy, stall, flush, vec_load} !== 4'b1000) begin n_fail++; $display("FAIL b2b_no_nesting: got %b want 1000", {busy, stall, flush, vec_load}); end
        drive_return(ws, rp, rf, rfl_flush, ok);
        n_tests++; if (ok !== 1'b1 || rp !== 32'h0001_2345) begin n_fail++; $display("FAIL b2b_return_pc: got %h want 00012345", rp); end
        drive_entry(4'b0000, ff, nf, np, ws, nv, vk, vp, ai, ok);
        n_tests++; if (ff !== 2) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d want 2", ff); end
        n_tests++; if (ai !== 2'd0 || vp !== 32'd0 || nv !== 1) begin n_fail++; $display("FAIL b2b_ch0_vec: got id %0d pc %h n %0d want 0 0 1", ai, vp, nv); end
        drive_return(ws, rp, rf, rfl_flush, ok);
        tick;
    endtask

    task automatic test_reset_mid_push;
        int n, n_act;
        n = 0; n_act = 0;
        irq_mask = 4'b0001; pc_in = 32'h1111_2222; flags_in = 3'b001; push_ready = 1'b1;
        irq = 4'b1001;
        for (int k = 1; k <= 40; k++) begin
            tick;
            irq = 4'b0000;
            if (push_valid && push_ready) begin
                n++;
                if (n == 2) begin
                    tick;
                    break;
                end
            end
        end
        n_tests++; if (push_valid !== 1'b1 || push_data !== 16'h0001) begin n_fail++; $display("FAIL rst_mid_push_state: got %b/%h want 1/0001", push_valid, push_data); end
        #2 reset = 1'b0;
        #1;
        n_tests++; if (all_out !== '0) begin n_fail++; $display("FAIL rst_async_outputs: got %h want 0", all_out); end
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        irq_mask = 4'b0000;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (busy || vec_load || flush) n_act++;
        end
        n_tests++; if (n_act !== 0) begin n_fail++; $display("FAIL rst_pending_cleared: got %0d active cycles want 0", n_act); end
        drive_entry(4'b1000, ff, nf, np, ws, nv, vk, vp, ai, ok);
        n_tests++; if (ok !== 1'b1 || vp !== 32'd6 || ai !== 2'd3) begin n_fail++; $display("FAIL rst_new_entry: got pc %h id %0d want 6 3", vp, ai); end
        drive_return(ws, rp, rf, rfl_flush, ok);
        n_tests++; if (rp !== 32'h1111_2222 || rf !== 3'b001) begin n_fail++; $display("FAIL rst_new_return: got %h/%b want 11112222/001", rp, rf); end
        tick;
    endtask

    initial begin
        test_reset;
        test_basic_entry;
        test_return;
        test_priority_mask;
        test_backpressure;
        test_back_to_back;
        test_reset_mid_push;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
